gate_op_arbiter: RTL and testbench

//  Shares one logic_gate unit (inputs a,b; outputs y0..y6) between NREQ requesters.

---
 rtl/gate_op_arbiter.sv | 109 ++++++++++
 tb/tb_gate_op_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_op_arbiter.sv
// gate_op_arbiter: round-robin sharing of one external logic_gate unit among NREQ requesters
// Ports: clk, rst (async, active-high); req_valid/req_op/req_a/req_b in, req_ready out (one-hot grant);
//   gate_a/gate_b registered operands to logic_gate, gate_y its {y6..y0} outputs;
//   rsp_valid/rsp_y/rsp_id/rsp_err out with rsp_ready in; op_count (only with GATE_ARB_STATS_EN defined).
module gate_op_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [3*NREQ-1:0] req_op,
  input  logic [NREQ-1:0]   req_a,
  input  logic [NREQ-1:0]   req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              gate_a,
  output logic              gate_b,
  input  logic [6:0]        gate_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_y,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_err
`ifdef GATE_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  op_count
`endif
);
  localparam int NP = 2**IDW;
  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;
  state_t state, state_nx;
  logic [IDW-1:0] ptr, g;
  logic [IDW:0] s;
  logic [NP-1:0] vpad;
  logic any, a_g, b_g;
  logic [2:0] op_g, op_q;
  logic [7:0] ypad;
  if (NREQ < 2 || NREQ > NP || CNT_W < 1) begin : g_bad_cfg
    $error("gate_op_arbiter: bad parameters");
  end
  // padding lets the rotating search index with a full IDW-bit value; op 7 selects the 0 pad bit
  assign vpad = NP'(req_valid);
  assign ypad = {1'b0, gate_y};
  // first valid requester at or after ptr, wrapping modulo NREQ
  always_comb begin
    g = '0;
    any = 1'b0;
    s = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = {1'b0, ptr} + (IDW+1)'(k);
      s = (s >= (IDW+1)'(NREQ)) ? s - (IDW+1)'(NREQ) : s;
      if (!any && vpad[s[IDW-1:0]]) begin
        any = 1'b1;
        g = s[IDW-1:0];
      end
    end
  end
  always_comb begin
    a_g = 1'b0;
    b_g = 1'b0;
    op_g = '0;
    for (int i = 0; i < NREQ; i++)
      if (g == IDW'(i)) begin
        a_g = req_a[i];
        b_g = req_b[i];
        op_g = req_op[3*i+:3];
      end
  end
  always_comb begin
    req_ready = (state == IDLE && any) ? NREQ'(1) << g : '0;
    state_nx = state == IDLE ? (any ? DRIVE : IDLE) : state == DRIVE ? RESP : (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      gate_a <= 1'b0;
      gate_b <= 1'b0;
      op_q <= '0;
      rsp_valid <= 1'b0;
      rsp_y <= 1'b0;
      rsp_id <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any) begin
        gate_a <= a_g;
        gate_b <= b_g;
        op_q <= op_g;
        rsp_id <= g;
        ptr <= (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;
      end
      if (state == DRIVE) begin
        rsp_y <= ypad[op_q];
        rsp_err <= &op_q;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready)
        rsp_valid <= 1'b0;
    end
`ifdef GATE_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst)
      op_count <= '0;
    else if (rsp_valid && rsp_ready && !(&op_count))
      op_count <= op_count + 1'b1;
`endif
endmodule

// File: tb/tb_gate_op_arbiter.sv
// tb_gate_op_arbiter: randomized scoreboard bench for gate_op_arbiter with a transaction-level reference model
module tb_gate_op_arbiter;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  typedef struct {int id; bit y; bit err;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_a = '0;
  logic [NREQ-1:0] req_b = '0;
  logic [3*NREQ-1:0] req_op = '0;
  logic [NREQ-1:0] req_ready;
  logic gate_a, gate_b, rsp_valid, rsp_y, rsp_err;
  logic rsp_ready = 1'b0;
  logic [6:0] gate_y;
  logic [IDW-1:0] rsp_id;
`ifdef GATE_ARB_STATS_EN
  logic [15:0] op_count;
`endif
  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  exp_t e;
  bit m_idle = 1'b1;
  int m_ptr = 0, m_lat = 0, m_done = 0, mdl_g, mon_g;
  logic [2:0] mdl_op;
  bit mon_exv;

  always #5 clk = ~clk;

  // stand-in for the external logic_gate unit
  assign gate_y = {~gate_a, ~(gate_a ^ gate_b), gate_a ^ gate_b, ~(gate_a | gate_b),
                   ~(gate_a & gate_b), gate_a | gate_b, gate_a & gate_b};

  gate_op_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .gate_a(gate_a), .gate_b(gate_b), .gate_y(gate_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_id(rsp_id), .rsp_err(rsp_err)
`ifdef GATE_ARB_STATS_EN
    , .op_count(op_count)
`endif
  );

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit ref_y(int op, bit a, bit b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return !(a && b);
      3: return !(a || b);
      4: return a ^ b;
      5: return a == b;
      6: return !a;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int find_grant();
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  // reference model: grants at the clock edge, pushes the expected response
  always @(posedge clk) begin
    if (rst) begin
      m_idle = 1'b1;
      m_ptr = 0;
      m_lat = 0;
      m_done = 0;
      exp_q.delete();
    end else if (m_idle) begin
      mdl_g = find_grant();
      if (mdl_g >= 0) begin
        mdl_op = 3'(req_op >> (3 * mdl_g));
        e.id = mdl_g;
        e.y = ref_y(int'(mdl_op), 1'(req_a >> mdl_g), 1'(req_b >> mdl_g));
        e.err = (mdl_op == 3'd7);
        exp_q.push_back(e);
        m_ptr = (mdl_g + 1) % NREQ;
        m_idle = 1'b0;
        m_lat = 0;
      end
    end else if (m_lat >= 1 && rsp_ready) begin
      m_idle = 1'b1;
      m_done++;
    end else
      m_lat++;
  end

  // monitor: compares DUT outputs mid-cycle, pops on the response handshake
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_rsp_y", int'(rsp_y), 0);
      chk("rst_rsp_id", int'(rsp_id), 0);
      chk("rst_rsp_err", int'(rsp_err), 0);
      chk("rst_gate_a", int'(gate_a), 0);
      chk("rst_gate_b", int'(gate_b), 0);
`ifdef GATE_ARB_STATS_EN
      chk("rst_op_count", int'(op_count), 0);
`endif
    end else begin
      mon_g = find_grant();
      chk("req_ready", int'(req_ready), (m_idle && mon_g >= 0) ? (1 << mon_g) : 0);
      mon_exv = !m_idle && m_lat >= 1;
      chk("rsp_valid", int'(rsp_valid), int'(mon_exv));
`ifdef GATE_ARB_STATS_EN
      chk("op_count", int'(op_count), m_done);
`endif
      if (mon_exv) begin
        if (exp_q.size() == 0)
          chk("scoreboard_empty", 1, 0);
        else begin
          chk("rsp_id", int'(rsp_id), exp_q[0].id);
          chk("rsp_y", int'(rsp_y), int'(exp_q[0].y));
          chk("rsp_err", int'(rsp_err), int'(exp_q[0].err));
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int i, int op, bit a, bit b);
    int n = 0;
    cyc();
    req_valid[i] = 1'b1;
    req_op[3*i+:3] = 3'(op);
    req_a[i] = a;
    req_b[i] = b;
    rsp_ready = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 50);
    chk("send_accept", int'(req_ready[i]), 1);
    cyc();
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    cyc();
    req_valid = '0;
    rsp_ready = 1'b1;
    while ((!m_idle || exp_q.size() != 0) && n < 50) begin
      cyc();
      n++;
    end
    chk("drain_done", int'(n < 50), 1);
  endtask

  task automatic run_rand(int cycles, int pv, int pr, int pd);
    logic [NREQ-1:0] acc;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      cyc();
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(99) < pv) begin
          req_valid[i] = 1'b1;
          req_op[3*i+:3] = 3'($urandom_range(7));
          req_a[i] = 1'($urandom);
          req_b[i] = 1'($urandom);
        end else if (req_valid[i] && $urandom_range(99) < pd)
          req_valid[i] = 1'b0;
      end
      rsp_ready = $urandom_range(99) < pr;
    end
  endtask

  task automatic reset_in_drive();
    int n = 0;
    cyc();
    req_valid = 4'b0001;
    req_op[2:0] = 3'd0;
    req_a[0] = 1'b1;
    req_b[0] = 1'b1;
    rsp_ready = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[0] && n < 50);
    chk("rst_test_accept", int'(req_ready[0]), 1);
    cyc();
    req_valid = '0;
    chk("drive_gate_a", int'(gate_a), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_gate_a", int'(gate_a), 0);
    chk("async_rst_gate_b", int'(gate_b), 0);
    chk("async_rst_rsp_valid", int'(rsp_valid), 0);
    chk("async_rst_req_ready", int'(req_ready), 0);
    chk("async_rst_rsp_err", int'(rsp_err), 0);
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send(0, 4, 1'b1, 1'b0);
    drain();
    for (int op = 0; op < 7; op++)
      for (int ab = 0; ab < 4; ab++)
        send(1, op, ab[1], ab[0]);
    drain();
    send(2, 7, 1'b1, 1'b1);
    send(2, 3, 1'b0, 1'b0);
    drain();
    run_rand(400, 100, 100, 0);
    drain();
    run_rand(1500, 30, 70, 3);
    drain();
    run_rand(600, 40, 15, 0);
    drain();
    reset_in_drive();
    run_rand(300, 100, 100, 0);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
